fb_port_arbiter: RTL and testbench
==================================

Name: fb_port_arbiter

Overview:
- Shares one single-port 64K x 1 framebuffer between two users: the display scanout and a host writer.
- Display reads have absolute priority. Host writes are queued in a 2-entry FIFO and issued in cycles where the display does not use the port (odd-x half of doubled pixels, blanking).
- Sits between the sync/position generators and the framebuffer memory, replacing the direct ROM hookup on LCD_CLK.

Parameters:
- ADDR_W, 16: framebuffer address width; address = {y[7:0], x[8:1]}.
- READ_LAT, 1: memory read latency in clocks, from ce to dout valid; legal range 1..3.
- STARVE_MAX, 1023: consecutive stalled cycles before the starvation flag sets; counter is 10 bits.

Ports:
- i_clk, in, 1: pixel clock (LCD_CLK).
- i_rst_n, in, 1: reset, asynchronous assert, active low.
- i_disp_req, in, 1: display needs a read this cycle.
- i_disp_addr, in, ADDR_W: display read address.
- o_pix, out, 1: read data returned to the display; 0 when not valid.
- o_pix_valid, out, 1: o_pix carries data for the request made READ_LAT cycles earlier.
- i_wr_valid, in, 1: host write offered.
- i_wr_addr, in, ADDR_W: host write address.
- i_wr_data, in, 1: host write data.
- o_wr_ready, out, 1: registered; FIFO can accept a write this cycle.
- o_mem_ce, out, 1: memory access enable.
- o_mem_we, out, 1: 1 = write, 0 = read.
- o_mem_addr, out, ADDR_W: memory address.
- o_mem_din, out, 1: memory write data.
- i_mem_dout, in, 1: memory read data.
- o_starved, out, 1: sticky starvation flag.
- i_clr_status, in, 1: clears o_starved.

Behaviour:
- Reset (i_rst_n=0, async):
  - FIFO count = 0; starvation counter = 0; read-valid pipe = 0.
  - Outputs: o_wr_ready=0, o_starved=0, o_pix=0, o_pix_valid=0.
  - Memory outputs o_mem_ce, o_mem_we, o_mem_addr, o_mem_din all 0.
- o_wr_ready goes to 1 on the first rising edge after reset release.
- Accept: a write is accepted when i_wr_valid & o_wr_ready at a rising edge, and is pushed to the FIFO tail. No write is lost or duplicated.
- Port grant is combinational each cycle:
  - If i_disp_req=1: o_mem_ce=1, o_mem_we=0, o_mem_addr=i_disp_addr.
  - Else if FIFO count > 0: o_mem_ce=1, o_mem_we=1, address/data taken from the FIFO head; the head pops at the clock edge.
  - Else o_mem_ce=0, o_mem_we=0, o_mem_addr=0, o_mem_din=0.
- Arbiter states, derived from FIFO count:
  - EMPTY (count 0), ONE (count 1), FULL (count 2).
  - count_next = count + push - pop.
  - Push and pop in the same cycle are allowed in ONE and FULL.
  - In EMPTY, an accepted write is not written the same cycle; it is issued the next free cycle at the earliest.
- Ready rule: o_wr_ready <= (count_next < 2). A push into ONE with no pop drops ready on the following cycle.
- Read return:
  - A shift register of depth READ_LAT carries the display grant.
  - o_pix_valid = tail of that shift register.
  - o_pix = i_mem_dout & o_pix_valid.
  - A write grant never produces o_pix_valid.
- Starvation counter:
  - Increments each cycle with count>0 and no pop; saturates at STARVE_MAX.
  - Clears to 0 on any pop or when count=0.
  - o_starved sets on the cycle after the counter reaches STARVE_MAX.
  - o_starved clears on i_clr_status. If i_clr_status coincides with a set condition, set wins.
- Hazard: a display read to an address with a pending write returns the old value. This is required behaviour; no forwarding.
- Addresses wrap naturally at 2^ADDR_W; no range checks.
- Reset mid-operation: FIFO contents are discarded. In-flight read valids are dropped; o_pix_valid=0 immediately.

Decomposition:
- Shared package fb_pkg holds:
  - FB_ADDR_W=16, FB_X_SHIFT=1, FB_Y_BITS=8.
  - The FIFO count encoding constants CNT_EMPTY, CNT_ONE, CNT_FULL.
- One sub-module: wr_fifo2. It is a 2-entry FIFO with async active-low reset, push/pop, count, head data/address, and registered ready.
- The grant mux, read pipe and starvation logic stay in fb_port_arbiter.

Test Plan:
- Reset, then i_disp_req=1, i_disp_addr=0x1234 -> same cycle o_mem_ce=1, o_mem_we=0, o_mem_addr=0x1234; with i_mem_dout=1 and READ_LAT=1 -> o_pix=1, o_pix_valid=1 on the next cycle.
- i_disp_req=0, write addr 0x00FF data 1 accepted -> next cycle o_mem_we=1, o_mem_addr=0x00FF, o_mem_din=1, FIFO returns to EMPTY.
- i_disp_req held 1, three back-to-back writes offered -> first two accepted, o_wr_ready=0 after the second, no o_mem_we. After i_disp_req drops -> writes issue in order over 2 cycles, then ready=1.
- Alternating i_disp_req (doubled-pixel pattern) with a continuous write stream -> every idle cycle issues a write; all display reads granted; no write lost.
- i_disp_req held 1 with one write pending for 1024 cycles -> o_starved=1 on cycle 1024. i_clr_status pulse after i_disp_req drops -> o_starved=0.
- Assert i_rst_n=0 with FIFO FULL and a read in flight -> immediately o_pix_valid=0, o_mem_ce=0, o_wr_ready=0. After release, no stale write is issued.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared framebuffer constants: address geometry, write-FIFO occupancy codes, port grant kinds.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fb_pkg;

    // Framebuffer address is {y[7:0], x[8:1]}: each stored pixel is shown twice horizontally.
    localparam int FB_ADDR_W  = 16;
    localparam int FB_X_SHIFT = 1;
    localparam int FB_Y_BITS  = 8;

    // Write-FIFO occupancy, which doubles as the arbiter state.
    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_ONE   = 2'd1;
    localparam logic [1:0] CNT_FULL  = 2'd2;

    // Which user owns the memory port this cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_RD   = 2'd1,
        GNT_WR   = 2'd2
    } grant_e;

endpackage

// File: rtl/wr_fifo2.sv
// Two-entry FIFO holding pending host writes (address + 1-bit data).
// Latency: a push is visible at the head one cycle later; pop removes the head at the clock edge.
// Backpressure: o_ready is registered, high when the occupancy after this edge is below two.
module wr_fifo2
    import fb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic              i_wr_data,
    input  logic              i_pop,
    output logic [1:0]        o_count,
    output logic [ADDR_W-1:0] o_head_addr,
    output logic              o_head_data,
    output logic              o_ready
);

    logic [ADDR_W-1:0] addr_q [0:1];
    logic [ADDR_W-1:0] addr_d [0:1];
    logic              data_q [0:1];
    logic              data_d [0:1];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              ready_q, ready_d;

    // Next-state: store on push, advance pointers, track occupancy and derive next ready.
    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (i_push) begin
            addr_d[wr_ptr_q] = i_wr_addr;
            data_d[wr_ptr_q] = i_wr_data;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (i_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, i_push} - {1'b0, i_pop};
        ready_d = (count_d < CNT_FULL);
    end

    // State registers; reset discards any queued writes and withholds ready.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_q[0] <= '0;
            addr_q[1] <= '0;
            data_q[0] <= 1'b0;
            data_q[1] <= 1'b0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= CNT_EMPTY;
            ready_q   <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            data_q    <= data_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ready_q   <= ready_d;
        end
    end

    assign o_count     = count_q;
    assign o_head_addr = addr_q[rd_ptr_q];
    assign o_head_data = data_q[rd_ptr_q];
    assign o_ready     = ready_q;

endmodule

// File: rtl/fb_port_arbiter.sv
// Shares the single-port framebuffer: display reads win, queued host writes fill idle cycles.
// Latency: grant is combinational; read data returns READ_LAT cycles after the display request.
// Backpressure: host writes stall via registered o_wr_ready when the 2-entry queue fills.
module fb_port_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W     = FB_ADDR_W,
    parameter int READ_LAT   = 1,
    parameter int STARVE_MAX = 1023
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_disp_req,
    input  logic [ADDR_W-1:0] i_disp_addr,
    output logic              o_pix,
    output logic              o_pix_valid,
    input  logic              i_wr_valid,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic              i_wr_data,
    output logic              o_wr_ready,
    output logic              o_mem_ce,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_din,
    input  logic              i_mem_dout,
    output logic              o_starved,
    input  logic              i_clr_status
);

    localparam int         STARVE_W   = 10;
    localparam logic [9:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    grant_e            grant;
    logic              push;
    logic              pop;
    logic [1:0]        fifo_count;
    logic [ADDR_W-1:0] head_addr;
    logic              head_data;
    logic              wr_ready;

    logic [READ_LAT-1:0] rd_pipe_q, rd_pipe_d;
    logic [9:0]          starve_cnt_q, starve_cnt_d;
    logic                starved_q, starved_d;
    logic                starve_set;

    assign push = i_wr_valid & wr_ready;
    assign pop  = (grant == GNT_WR);

    wr_fifo2 #(.ADDR_W(ADDR_W)) u_wr_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (push),
        .i_wr_addr   (i_wr_addr),
        .i_wr_data   (i_wr_data),
        .i_pop       (pop),
        .o_count     (fifo_count),
        .o_head_addr (head_addr),
        .o_head_data (head_data),
        .o_ready     (wr_ready)
    );

    // Port grant: display first, then the FIFO head; nothing is granted while reset is held
    // so the memory sees an idle port the instant reset asserts.
    always_comb begin
        grant = GNT_NONE;
        if (i_rst_n) begin
            if (i_disp_req) begin
                grant = GNT_RD;
            end else if (fifo_count != CNT_EMPTY) begin
                grant = GNT_WR;
            end
        end
    end

    // Memory port drive; idle port is held at all-zero.
    always_comb begin
        o_mem_ce   = 1'b0;
        o_mem_we   = 1'b0;
        o_mem_addr = '0;
        o_mem_din  = 1'b0;
        unique case (grant)
            GNT_RD: begin
                o_mem_ce   = 1'b1;
                o_mem_addr = i_disp_addr;
            end
            GNT_WR: begin
                o_mem_ce   = 1'b1;
                o_mem_we   = 1'b1;
                o_mem_addr = head_addr;
                o_mem_din  = head_data;
            end
            default: ;
        endcase
    end

    // Read-return pipe: shifts the display grant along to line up with memory read latency.
    always_comb begin
        rd_pipe_d    = rd_pipe_q;
        rd_pipe_d[0] = (grant == GNT_RD);
        for (int i = 1; i < READ_LAT; i++) begin
            rd_pipe_d[i] = rd_pipe_q[i-1];
        end
    end

    // Starvation: count consecutive cycles a queued write waits; the flag is sticky until cleared,
    // and a coincident set beats the clear.
    always_comb begin
        starve_set = (starve_cnt_q == STARVE_LIM);
        if ((fifo_count != CNT_EMPTY) && !pop) begin
            starve_cnt_d = starve_set ? starve_cnt_q : starve_cnt_q + 10'd1;
        end else begin
            starve_cnt_d = '0;
        end
        starved_d = starve_set | (starved_q & ~i_clr_status);
    end

    // Read pipe and starvation registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_pipe_q    <= '0;
            starve_cnt_q <= '0;
            starved_q    <= 1'b0;
        end else begin
            rd_pipe_q    <= rd_pipe_d;
            starve_cnt_q <= starve_cnt_d;
            starved_q    <= starved_d;
        end
    end

    assign o_pix_valid = rd_pipe_q[READ_LAT-1];
    assign o_pix       = i_mem_dout & o_pix_valid;
    assign o_wr_ready  = wr_ready;
    assign o_starved   = starved_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with a queue-based reference model and a 64K x 1 memory.
// Latency: memory model returns read data one clock after ce (READ_LAT = 1).
// Backpressure: host write driver offers each write until the reference says it was taken.
module tb_fb_port_arbiter;

    localparam int AW = 16;

    logic          i_clk;
    logic          i_rst_n;
    logic          i_disp_req;
    logic [AW-1:0] i_disp_addr;
    logic          o_pix;
    logic          o_pix_valid;
    logic          i_wr_valid;
    logic [AW-1:0] i_wr_addr;
    logic          i_wr_data;
    logic          o_wr_ready;
    logic          o_mem_ce;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic          o_mem_din;
    logic          i_mem_dout;
    logic          o_starved;
    logic          i_clr_status;

    fb_port_arbiter #(.ADDR_W(AW), .READ_LAT(1), .STARVE_MAX(1023)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_disp_req   (i_disp_req),
        .i_disp_addr  (i_disp_addr),
        .o_pix        (o_pix),
        .o_pix_valid  (o_pix_valid),
        .i_wr_valid   (i_wr_valid),
        .i_wr_addr    (i_wr_addr),
        .i_wr_data    (i_wr_data),
        .o_wr_ready   (o_wr_ready),
        .o_mem_ce     (o_mem_ce),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_din    (o_mem_din),
        .i_mem_dout   (i_mem_dout),
        .o_starved    (o_starved),
        .i_clr_status (i_clr_status)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Physical memory driven by the DUT port.
    logic mem [0:65535];
    int   n_dut_wr = 0;
    always @(posedge i_clk) begin
        if (o_mem_ce && !o_mem_we) i_mem_dout <= mem[o_mem_addr];
        if (o_mem_ce && o_mem_we) begin
            mem[o_mem_addr] <= o_mem_din;
            n_dut_wr++;
        end
    end

    // Reference model: pending writes as a queue, framebuffer as an array.
    typedef struct { logic [AW-1:0] a; logic d; } wr_t;
    wr_t  mq[$];
    bit   ref_fb [0:65535];
    bit   m_ready, m_starved, m_pix_vld, m_pix_val;
    int   m_run;      // consecutive cycles a queued write has waited
    int   m_pops = 0;

    always @(posedge i_clk) begin
        bit had, pop, push, set;
        if (!i_rst_n) begin
            mq.delete();
            m_ready = 0; m_starved = 0; m_pix_vld = 0; m_pix_val = 0; m_run = 0;
        end else begin
            had  = (mq.size() > 0);
            pop  = had && !i_disp_req;
            push = i_wr_valid && m_ready;
            set  = (m_run == 1023);
            m_pix_vld = i_disp_req;
            m_pix_val = i_disp_req ? ref_fb[i_disp_addr] : 1'b0;
            if (pop) begin
                ref_fb[mq[0].a] = mq[0].d;
                void'(mq.pop_front());
                m_pops++;
            end
            if (push) mq.push_back('{i_wr_addr, i_wr_data});
            m_run     = (had && !pop) ? ((m_run < 1023) ? m_run + 1 : 1023) : 0;
            m_starved = set || (m_starved && !i_clr_status);
            m_ready   = (mq.size() < 2);
        end
    end

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            check("cyc_rst_ce", o_mem_ce, 0);
            check("cyc_rst_we", o_mem_we, 0);
            check("cyc_rst_addr", o_mem_addr, 0);
            check("cyc_rst_din", o_mem_din, 0);
            check("cyc_rst_ready", o_wr_ready, 0);
            check("cyc_rst_pixv", o_pix_valid, 0);
            check("cyc_rst_pix", o_pix, 0);
            check("cyc_rst_starved", o_starved, 0);
        end else begin
            if (i_disp_req) begin
                check("cyc_rd_ce", o_mem_ce, 1);
                check("cyc_rd_we", o_mem_we, 0);
                check("cyc_rd_addr", o_mem_addr, i_disp_addr);
            end else if (mq.size() > 0) begin
                check("cyc_wr_ce", o_mem_ce, 1);
                check("cyc_wr_we", o_mem_we, 1);
                check("cyc_wr_addr", o_mem_addr, mq[0].a);
                check("cyc_wr_din", o_mem_din, mq[0].d);
            end else begin
                check("cyc_idle_ce", o_mem_ce, 0);
                check("cyc_idle_we", o_mem_we, 0);
                check("cyc_idle_addr", o_mem_addr, 0);
                check("cyc_idle_din", o_mem_din, 0);
            end
            check("cyc_ready", o_wr_ready, m_ready);
            check("cyc_pixv", o_pix_valid, m_pix_vld);
            check("cyc_pix", o_pix, m_pix_vld & m_pix_val);
            check("cyc_starved", o_starved, m_starved);
        end
    end

    // Offer n sequential writes starting at base; returns how many were accepted within max_cyc.
    task automatic wr_stream(input int n, input logic [AW-1:0] base, input int max_cyc,
                             output int accepted);
        bit acc;
        accepted = 0;
        for (int c = 0; c < max_cyc && accepted < n; c++) begin
            i_wr_valid = 1'b1;
            i_wr_addr  = base + AW'(accepted);
            i_wr_data  = accepted[0];
            @(negedge i_clk);
            acc = m_ready && i_rst_n;
            @(posedge i_clk); #1;
            if (acc) accepted++;
        end
        i_wr_valid = 1'b0;
    endtask

    initial begin
        int acc;
        int wr0;
        for (int a = 0; a < 65536; a++) begin
            mem[a]    = 1'b0;
            ref_fb[a] = 1'b0;
        end
        mem[16'h1234]    = 1'b1;
        ref_fb[16'h1234] = 1'b1;
        i_mem_dout   = 1'b0;
        i_disp_req   = 1'b0;
        i_disp_addr  = '0;
        i_wr_valid   = 1'b0;
        i_wr_addr    = '0;
        i_wr_data    = 1'b0;
        i_clr_status = 1'b0;
        i_rst_n      = 1'b1;
        #1 i_rst_n   = 1'b0;

        // Reset state
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_ready", o_wr_ready, 0);
        check("rst_ce", o_mem_ce, 0);
        check("rst_pix_valid", o_pix_valid, 0);
        check("rst_starved", o_starved, 0);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        check("ready_after_release", o_wr_ready, 1);

        // Display read, 1-cycle return
        i_disp_req = 1'b1; i_disp_addr = 16'h1234;
        #1;
        check("rd_ce", o_mem_ce, 1);
        check("rd_we", o_mem_we, 0);
        check("rd_addr", o_mem_addr, 16'h1234);
        @(posedge i_clk); #1;
        i_disp_req = 1'b0;
        check("rd_pix", o_pix, 1);
        check("rd_pix_valid", o_pix_valid, 1);

        // Single write into idle port
        i_wr_valid = 1'b1; i_wr_addr = 16'h00FF; i_wr_data = 1'b1;
        @(posedge i_clk); #1;
        i_wr_valid = 1'b0;
        check("wr1_we", o_mem_we, 1);
        check("wr1_addr", o_mem_addr, 16'h00FF);
        check("wr1_din", o_mem_din, 1);
        @(posedge i_clk); #1;
        check("wr1_empty_ce", o_mem_ce, 0);

        // Display holds the port: queue fills at two
        i_disp_req = 1'b1; i_disp_addr = 16'h0050;
        wr0 = n_dut_wr;
        wr_stream(3, 16'h0200, 4, acc);
        check("full_accepted", acc, 2);
        check("full_ready", o_wr_ready, 0);
        check("full_no_writes", n_dut_wr - wr0, 0);
        i_disp_req = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        check("drain_writes", n_dut_wr - wr0, 2);
        check("drain_ready", o_wr_ready, 1);
        check("drain_ce", o_mem_ce, 0);

        // Doubled-pixel pattern with a write stream, addresses overlapping the writes
        wr0 = n_dut_wr;
        fork
            begin
                int got;
                wr_stream(8, 16'h0100, 40, got);
                acc = got;
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    i_disp_req  = (c[0] == 1'b0);
                    i_disp_addr = 16'h0100 + 16'(c >> 2);
                    @(posedge i_clk); #1;
                end
                i_disp_req = 1'b0;
            end
        join
        check("alt_accepted", acc, 8);
        check("alt_writes", n_dut_wr - wr0, 8);

        // Starvation with one stalled write
        i_disp_req = 1'b1; i_disp_addr = 16'h0010;
        i_wr_valid = 1'b1; i_wr_addr = 16'h0300; i_wr_data = 1'b1;
        @(posedge i_clk); #1;
        i_wr_valid = 1'b0;
        repeat (1023) @(posedge i_clk);
        #1;
        check("starve_1023", o_starved, 0);
        @(posedge i_clk); #1;
        check("starve_1024", o_starved, 1);
        i_disp_req = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        check("starve_sticky", o_starved, 1);
        i_clr_status = 1'b1;
        @(posedge i_clk); #1;
        i_clr_status = 1'b0;
        check("starve_cleared", o_starved, 0);

        // Reset with queue full and a read in flight
        i_disp_req = 1'b1; i_disp_addr = 16'h0400;
        wr_stream(2, 16'h0400, 4, acc);
        check("rst2_accepted", acc, 2);
        check("rst2_inflight", o_pix_valid, 1);
        i_rst_n = 1'b0;
        #1;
        check("rst2_pix_valid", o_pix_valid, 0);
        check("rst2_ce", o_mem_ce, 0);
        check("rst2_ready", o_wr_ready, 0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        i_disp_req = 1'b0;
        wr0 = n_dut_wr;
        repeat (5) @(posedge i_clk);
        #1;
        check("rst2_no_stale", n_dut_wr - wr0, 0);
        check("rst2_ready", o_wr_ready, 1);

        check("total_writes", n_dut_wr, m_pops);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
